// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ----------------
// Pipeline register and operand-forwarding stage between instruction decode
// and the combinational ALU. One decoded instruction is captured per cycle
// and presented to the ALU on the following cycle.
//
// RAW hazards are resolved as follows:
//   - Forwarding from EX/MEM, which has priority, and from MEM/WB onto the
//     registered source fields.
//   - A write-through at capture time from MEM/WB, because the register file
//     read in decode may still hold the stale value.
//
// Load-use hazards raise `stall` for one cycle. During that cycle a bubble
// is inserted. A bubble reaches the ALU as NULL_OP with zero operands.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   id_*                 decoded instruction from the decode stage
//   flush                kill the instruction entering this stage
//   exm_*                EX/MEM writeback info (forward source, priority)
//   wb_*                 MEM/WB writeback info (forward + write-through)
//   stall                load-use hazard, freeze PC and IF/ID
//   alu_in0/alu_in1/alu_op  ALU drive
//   ex_*                 stage contents passed downstream
module ex_operand_stage #(
  parameter int          XLEN    = 32,
  parameter logic [3:0]  NULL_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [3:0]      id_aluop,
  input  logic [4:0]      id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            flush,
  input  logic            exm_regwrite,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  output logic [3:0]      alu_op,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic [XLEN-1:0] ex_store_data
);

  // Stage register fields
  logic            valid_q,    valid_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [XLEN-1:0] rs1_val_q,  rs1_val_d;
  logic [XLEN-1:0] rs2_val_q,  rs2_val_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic            alusrc_q,   alusrc_d;
  logic [3:0]      aluop_q,    aluop_d;
  logic [4:0]      rd_q,       rd_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q,  memread_d;

  logic            load_id;
  logic [XLEN-1:0] opa, opb;

  // MEM/WB write-through. The register file has not yet been written with
  // wb_data when decode reads it, so the value must be patched on capture.
  function automatic logic [XLEN-1:0] write_through(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_val,
    input logic            w_en,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_data
  );
    if (w_en && (w_rd != 5'd0) && (w_rd == rs)) return w_data;
    return rf_val;
  endfunction

  // Operand forwarding. EX/MEM is the younger result, so it wins. x0 never
  // forwards.
  function automatic logic [XLEN-1:0] forward(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] stored,
    input logic            x_en,
    input logic [4:0]      x_rd,
    input logic [XLEN-1:0] x_res,
    input logic            w_en,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_data
  );
    if (x_en && (x_rd != 5'd0) && (x_rd == rs)) return x_res;
    if (w_en && (w_rd != 5'd0) && (w_rd == rs)) return w_data;
    return stored;
  endfunction

  // A load in the stage whose destination is read by decode must wait one
  // cycle. rs2 is compared regardless of alusrc, because the instruction
  // format is not decoded here. A flush overrides the stall, since the
  // decode instruction is being killed anyway.
  always_comb begin
    stall = !flush && id_valid && valid_q && memread_q && (rd_q != 5'd0) &&
            ((rd_q == id_rs1) || (rd_q == id_rs2));
  end

  assign load_id = !flush && !stall && id_valid;

  always_comb begin
    valid_d    = 1'b0;
    rs1_d      = '0;
    rs2_d      = '0;
    rs1_val_d  = '0;
    rs2_val_d  = '0;
    imm_d      = '0;
    alusrc_d   = 1'b0;
    aluop_d    = NULL_OP;
    rd_d       = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    if (load_id) begin
      valid_d    = 1'b1;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rs1_val_d  = write_through(id_rs1, id_rs1_val, wb_regwrite, wb_rd, wb_data);
      rs2_val_d  = write_through(id_rs2, id_rs2_val, wb_regwrite, wb_rd, wb_data);
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      aluop_d    = id_aluop;
      rd_d       = id_rd;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= NULL_OP;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  always_comb begin
    opa = forward(rs1_q, rs1_val_q, exm_regwrite, exm_rd, exm_result,
                  wb_regwrite, wb_rd, wb_data);
    opb = forward(rs2_q, rs2_val_q, exm_regwrite, exm_rd, exm_result,
                  wb_regwrite, wb_rd, wb_data);
  end

  // Bubbles are forced to the ALU null op with zero operands. This holds
  // even though forwarding could otherwise match against stale fields.
  always_comb begin
    alu_in0       = '0;
    alu_in1       = '0;
    ex_store_data = '0;
    alu_op        = NULL_OP;
    if (valid_q) begin
      alu_in0       = opa;
      alu_in1       = alusrc_q ? imm_q : opb;
      ex_store_data = opb;
      alu_op        = aluop_q;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rstn;
  logic            id_valid;
  logic [4:0]      id_rs1, id_rs2;
  logic [XLEN-1:0] id_rs1_val, id_rs2_val, id_imm;
  logic            id_alusrc;
  logic [3:0]      id_aluop;
  logic [4:0]      id_rd;
  logic            id_regwrite, id_memread;
  logic            flush;
  logic            exm_regwrite;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_result;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic [XLEN-1:0] alu_in0, alu_in1, ex_store_data;
  logic [3:0]      alu_op;
  logic            ex_valid, ex_regwrite, ex_memread;
  logic [4:0]      ex_rd;

  ex_operand_stage #(.XLEN(XLEN), .NULL_OP(4'b1111)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [3:0]  op;
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [31:0] sd;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] in0, input logic [31:0] in1,
                          input logic [3:0] op, input logic v, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic [31:0] sd);
    exp_t e;
    e.tag = tag; e.in0 = in0; e.in1 = in1; e.op = op; e.v = v;
    e.rd = rd; e.rw = rw; e.mr = mr; e.sd = sd;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".alu_in0"},  alu_in0,                e.in0);
    chk({e.tag, ".alu_in1"},  alu_in1,                e.in1);
    chk({e.tag, ".alu_op"},   {28'd0, alu_op},        {28'd0, e.op});
    chk({e.tag, ".ex_valid"}, {31'd0, ex_valid},      {31'd0, e.v});
    chk({e.tag, ".ex_rd"},    {27'd0, ex_rd},         {27'd0, e.rd});
    chk({e.tag, ".ex_rw"},    {31'd0, ex_regwrite},   {31'd0, e.rw});
    chk({e.tag, ".ex_mr"},    {31'd0, ex_memread},    {31'd0, e.mr});
    chk({e.tag, ".store"},    ex_store_data,          e.sd);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp});
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [31:0] rs1v,
                          input logic [4:0] rs2, input logic [31:0] rs2v,
                          input logic [31:0] imm, input logic alusrc, input logic [3:0] op,
                          input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_val = rs1v; id_rs2 = rs2; id_rs2_val = rs2v;
    id_imm = imm; id_alusrc = alusrc; id_aluop = op; id_rd = rd;
    id_regwrite = rw; id_memread = mr;
  endtask

  task automatic fwd_off();
    exm_regwrite = 1'b0; exm_rd = 5'd0; exm_result = '0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = '0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    flush   = 1'b0;
    fwd_off();
    drive_id(1'b0, 5'd0, '0, 5'd0, '0, '0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);

    // Reset held: toggle inputs, everything must stay at reset values
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom,
               $urandom, 1'($urandom), 4'($urandom), 5'($urandom_range(1, 31)), 1'b1, 1'b1);
      exm_regwrite = 1'b1; exm_rd = id_rs1; exm_result = $urandom;
      edge1();
      push_exp("reset", 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
      check_out();
      chk_stall("reset", 1'b0);
    end

    // Release reset away from the clock edge, then issue add x3,x1,x2
    fwd_off();
    rstn = 1'b1;
    drive_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 4'b0000, 5'd3, 1'b1, 1'b0);
    edge1();
    push_exp("add", 32'd5, 32'd7, 4'b0000, 1'b1, 5'd3, 1'b1, 1'b0, 32'd7);
    check_out();

    // Forwarding priority on the held add (rs1=1)
    drive_id(1'b0, 5'd0, '0, 5'd0, '0, '0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    exm_regwrite = 1'b1; exm_rd = 5'd1; exm_result = 32'h11;
    wb_regwrite  = 1'b1; wb_rd  = 5'd1; wb_data    = 32'h22;
    #1;
    push_exp("fwd_exm", 32'h11, 32'd7, 4'b0000, 1'b1, 5'd3, 1'b1, 1'b0, 32'd7);
    check_out();
    exm_regwrite = 1'b0;
    #1;
    push_exp("fwd_wb", 32'h22, 32'd7, 4'b0000, 1'b1, 5'd3, 1'b1, 1'b0, 32'd7);
    check_out();
    exm_regwrite = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    #1;
    push_exp("fwd_x0", 32'd5, 32'd7, 4'b0000, 1'b1, 5'd3, 1'b1, 1'b0, 32'd7);
    check_out();
    fwd_off();

    // Load-use: lw x4, 8(x5) followed by sub x6, x7, x4
    drive_id(1'b1, 5'd5, 32'h100, 5'd0, 32'd0, 32'd8, 1'b1, 4'b0000, 5'd4, 1'b1, 1'b1);
    edge1();
    push_exp("load", 32'h100, 32'd8, 4'b0000, 1'b1, 5'd4, 1'b1, 1'b1, 32'd0);
    check_out();
    drive_id(1'b1, 5'd7, 32'h30, 5'd4, 32'd0, 32'd0, 1'b0, 4'b0001, 5'd6, 1'b1, 1'b0);
    #1;
    chk_stall("lu_detect", 1'b1);
    edge1();
    push_exp("lu_bubble", 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    check_out();
    chk_stall("lu_release", 1'b0);
    exm_regwrite = 1'b1; exm_rd = 5'd4; exm_result = 32'h99;
    edge1();
    push_exp("lu_sub", 32'h30, 32'h99, 4'b0001, 1'b1, 5'd6, 1'b1, 1'b0, 32'h99);
    check_out();
    fwd_off();

    // Flush together with a load-use hazard
    drive_id(1'b1, 5'd5, 32'h100, 5'd0, 32'd0, 32'd8, 1'b1, 4'b0000, 5'd4, 1'b1, 1'b1);
    edge1();
    push_exp("load2", 32'h100, 32'd8, 4'b0000, 1'b1, 5'd4, 1'b1, 1'b1, 32'd0);
    check_out();
    drive_id(1'b1, 5'd7, 32'h30, 5'd4, 32'd0, 32'd0, 1'b0, 4'b0001, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk_stall("flush_stall", 1'b0);
    edge1();
    flush = 1'b0;
    push_exp("flush_bubble", 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    check_out();

    // Immediate path with a pending rs2 forward; rs1 is x0 holding junk
    drive_id(1'b1, 5'd0, 32'h7, 5'd9, 32'h1, 32'hFFFF_FFFC, 1'b1, 4'b0000, 5'd10, 1'b1, 1'b0);
    edge1();
    exm_regwrite = 1'b1; exm_rd = 5'd9; exm_result = 32'hABCD;
    #1;
    push_exp("imm_fwd", 32'h7, 32'hFFFF_FFFC, 4'b0000, 1'b1, 5'd10, 1'b1, 1'b0, 32'hABCD);
    check_out();
    exm_rd = 5'd0; exm_result = 32'hDEAD;
    #1;
    push_exp("imm_x0", 32'h7, 32'hFFFF_FFFC, 4'b0000, 1'b1, 5'd10, 1'b1, 1'b0, 32'h1);
    check_out();
    fwd_off();

    // Write-through at capture: stale rs1 value patched from MEM/WB
    drive_id(1'b1, 5'd2, 32'd0, 5'd3, 32'h4, 32'd0, 1'b0, 4'b0010, 5'd5, 1'b1, 1'b0);
    wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
    edge1();
    fwd_off();
    #1;
    push_exp("write_thru", 32'h55, 32'h4, 4'b0010, 1'b1, 5'd5, 1'b1, 1'b0, 32'h4);
    check_out();

    // id_valid=0 loads a bubble
    drive_id(1'b0, 5'd1, 32'h1234, 5'd2, 32'h5678, 32'd3, 1'b0, 4'b0000, 5'd8, 1'b1, 1'b1);
    edge1();
    push_exp("idle", 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    check_out();

    // Asynchronous reset mid-operation, no clock edge between assert and check
    drive_id(1'b1, 5'd1, 32'h1234, 5'd2, 32'h5678, 32'd0, 1'b0, 4'b0001, 5'd8, 1'b1, 1'b1);
    edge1();
    push_exp("pre_areset", 32'h1234, 32'h5678, 4'b0001, 1'b1, 5'd8, 1'b1, 1'b1, 32'h5678);
    check_out();
    #1;
    rstn = 1'b0;
    #1;
    push_exp("areset", 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    check_out();
    chk_stall("areset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
